alu_mdu: RTL
============

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8 to 64.
REQ-002 clk  input  1  the only clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  a request is presented on A, B, Mode, ALUFun and Sign.
REQ-005 in_ready  output  1  the block accepts a request this cycle.
REQ-006 Mode  input  2  operation class: 00 ALU, 01 MUL, 10 DIV, 11 treated as ALU.
REQ-007 ALUFun  input  6  ALU function; used only when Mode is 00 or 11.
REQ-008 Sign  input  1  1 selects signed arithmetic, compare, multiply and divide.
REQ-009 A, B  input  WIDTH each  operands.
REQ-010 out_valid  output  1  S, Hi and DivZero hold a completed result.
REQ-011 out_ready  input  1  the consumer takes the result.
REQ-012 S  output  WIDTH  ALU result, or the low half (MUL) or quotient (DIV).
REQ-013 Hi  output  WIDTH  product high half or remainder.
REQ-014 DivZero  output  1  the last DIV had B equal to 0.

Function
REQ-015 The state machine SHALL have the states IDLE, MUL, DIV, FIX and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept condition: in_valid and in_ready on the same rising edge; operands SHALL be latched at that edge, and later input changes SHALL have no effect.
REQ-017 ALU request: the result SHALL be registered at the accept edge and the block SHALL enter DONE, so out_valid is 1 one cycle after accept.
REQ-018 ALUFun[5:4]=00 SHALL give A+B, or A-B when ALUFun[0]=1; the result SHALL be modulo 2^WIDTH.
REQ-019 ALUFun[5:4]=01 SHALL select by ALUFun[3:0]: 0001 NOR, 0110 XOR, 1000 AND, 1110 OR; any other code SHALL pass A.
REQ-020 ALUFun[5:4]=10 SHALL shift B by the amount A[log2(WIDTH)-1:0]: ALUFun[1:0] 00 SLL, 01 SRL, 11 SRA, 10 SLL.
REQ-021 ALUFun[5:4]=11 SHALL produce a 0/1 compare result in S[0], with all other bits 0.
REQ-022 Compare codes ALUFun[3:1]: 000 A!=B, 001 A==B, 010 A<B, 101 A<0, 110 A<=0, 111 A>0; any other code SHALL give 0.
REQ-023 Compares SHALL be signed when Sign=1 and unsigned otherwise, and SHALL be exact with no overflow error.
REQ-024 MUL: the block SHALL run a shift-add iteration of exactly WIDTH cycles in state MUL, then one FIX cycle for sign correction, then DONE.
REQ-025 MUL result: out_valid SHALL rise WIDTH+2 cycles after accept, with the 2*WIDTH-bit product in {Hi,S}.
REQ-026 DIV: the block SHALL run a restoring iteration on magnitudes for WIDTH cycles, then FIX, then DONE, with the same latency as MUL.
REQ-027 DIV result: S SHALL be the quotient truncated toward zero and Hi the remainder, which takes the sign of A.
REQ-028 DIV with B=0: S SHALL be all ones, Hi SHALL be A, DivZero SHALL be 1, and the latency SHALL be unchanged.
REQ-029 Signed DIV of the most-negative A by -1 SHALL give S equal to the most-negative value and Hi equal to 0, with no error.
REQ-030 DONE: out_valid SHALL be 1, and S, Hi and DivZero SHALL be stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-031 A new request SHALL be accepted no earlier than the cycle after the handshake completes, so there is no back-to-back overlap.
REQ-032 An ALU operation SHALL leave Hi and DivZero unchanged, and a MUL SHALL clear DivZero.

Reset
REQ-033 On a clock edge with reset=0: state SHALL become IDLE, out_valid SHALL become 0, and S, Hi, DivZero and all internal registers SHALL become 0.
REQ-034 After reset, in_ready SHALL be 1 on the first cycle with reset=1.
REQ-035 Reset during MUL, DIV, FIX or DONE SHALL abort the operation; no result SHALL be presented.

Verification (WIDTH=32)
REQ-036 ALU sub: ALUFun=000001, A=5, B=7 -> S=0xFFFFFFFE one cycle after accept, Hi unchanged.
REQ-037 Signed MUL: A=0xFFFFFFFE (-2), B=3, Sign=1 -> out_valid at cycle 34, Hi=0xFFFFFFFF, S=0xFFFFFFFA.
REQ-038 Signed DIV: A=-7, B=2 -> S=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); and A=9, B=0 -> S=0xFFFFFFFF, Hi=9, DivZero=1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; release -> IDLE next cycle.
REQ-040 Reset at cycle 10 of a DIV -> out_valid=0 and in_ready=1 after reset is released, with no stale result; SRA A=4, B=0x80000000 -> S=0xF8000000.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Request/response bundle for alu_mdu: operands and opcode travel in under
// in_valid/in_ready, and the result travels out under out_valid/out_ready.
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       Mode;
  logic [5:0]       ALUFun;
  logic             Sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Hi;
  logic             DivZero;

  modport master (
    output in_valid, Mode, ALUFun, Sign, A, B, out_ready,
    input  in_ready, out_valid, S, Hi, DivZero
  );

  modport slave (
    input  in_valid, Mode, ALUFun, Sign, A, B, out_ready,
    output in_ready, out_valid, S, Hi, DivZero
  );
endinterface

// File: rtl/alu_mdu.sv
// Single-issue ALU with an iterative multiply/divide unit: ALU ops finish at the
// accept edge, MUL/DIV run WIDTH iterations on magnitudes plus a sign-fix cycle.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] hi_r;
  logic             dz_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb_in;
  logic               a_neg;
  logic               b_neg;
  logic               lt;
  logic               a_zero;
  logic [CW-1:0]      shamt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.S         = s_r;
  assign bus.Hi        = hi_r;
  assign bus.DivZero   = dz_r;

  // Operand decode and the single-cycle ALU, evaluated on the live request.
  always_comb begin
    a_neg   = bus.Sign & bus.A[WIDTH-1];
    b_neg   = bus.Sign & bus.B[WIDTH-1];
    ma      = a_neg ? -bus.A : bus.A;
    mb_in   = b_neg ? -bus.B : bus.B;
    lt      = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
    a_zero  = (bus.A == '0);
    shamt   = bus.A[CW-1:0];
    alu_res = bus.A;
    case (bus.ALUFun[5:4])
      2'b00: alu_res = bus.ALUFun[0] ? (bus.A - bus.B) : (bus.A + bus.B);
      2'b01: begin
        case (bus.ALUFun[3:0])
          4'b0001: alu_res = ~(bus.A | bus.B);
          4'b0110: alu_res = bus.A ^ bus.B;
          4'b1000: alu_res = bus.A & bus.B;
          4'b1110: alu_res = bus.A | bus.B;
          default: alu_res = bus.A;
        endcase
      end
      2'b10: begin
        case (bus.ALUFun[1:0])
          2'b01:   alu_res = bus.B >> shamt;
          2'b11:   alu_res = $signed(bus.B) >>> shamt;
          default: alu_res = bus.B << shamt;
        endcase
      end
      default: begin
        // a_neg is already gated by Sign, so unsigned A is never below zero.
        alu_res = '0;
        case (bus.ALUFun[3:1])
          3'b000:  alu_res[0] = (bus.A != bus.B);
          3'b001:  alu_res[0] = (bus.A == bus.B);
          3'b010:  alu_res[0] = lt;
          3'b101:  alu_res[0] = a_neg;
          3'b110:  alu_res[0] = a_neg | a_zero;
          3'b111:  alu_res[0] = ~a_neg & ~a_zero;
          default: alu_res[0] = 1'b0;
        endcase
      end
    endcase
  end

  // One iteration step of each engine plus the signed product for FIX.
  always_comb begin
    mul_sum   = acc + (q[0] ? {1'b0, mb} : '0);
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mb};
    prod      = {acc[WIDTH-1:0], q};
    if (neg_q) begin
      prod = -prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      s_r         <= '0;
      hi_r        <= '0;
      dz_r        <= 1'b0;
      a_r         <= '0;
      mb          <= '0;
      q           <= '0;
      acc         <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.A;
            mb      <= mb_in;
            q       <= ma;
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz_pend <= (bus.B == '0);
            case (bus.Mode)
              2'b01: begin
                is_div <= 1'b0;
                state  <= MUL;
              end
              2'b10: begin
                is_div <= 1'b1;
                state  <= DIV;
              end
              default: begin
                s_r         <= alu_res;
                out_valid_r <= 1'b1;
                state       <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          acc <= {1'b0, mul_sum[WIDTH:1]};
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        DIV: begin
          // Restoring step: keep the partial remainder when the subtract underflows.
          if (div_diff[WIDTH]) begin
            acc <= div_shift;
            q   <= {q[WIDTH-2:0], 1'b0};
          end else begin
            acc <= div_diff;
            q   <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            dz_r <= dz_pend;
            if (dz_pend) begin
              s_r  <= '1;
              hi_r <= a_r;
            end else begin
              s_r  <= neg_q ? -q : q;
              hi_r <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
          end else begin
            dz_r <= 1'b0;
            s_r  <= prod[WIDTH-1:0];
            hi_r <= prod[2*WIDTH-1:WIDTH];
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
